// File: rtl/or_16_pkg.sv
// Shared constants and NAND helper for the 16-bit gate library.
package or_16_pkg;

  localparam int WORD_W = 16;

  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

endpackage

// File: rtl/or_16_or.sv
// 1-bit 2-input OR built from NAND stages: or = nand(nand(a,a), nand(b,b)).
// Purely combinational, no state, no flow control.
module or_16_or
  import or_16_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic y
);

  logic na;
  logic nb;

  assign na = nand2(a, a);
  assign nb = nand2(b, b);
  assign y  = nand2(na, nb);

endmodule

// File: rtl/or_16.sv
// Bitwise 16-bit OR: out is combinational (0 cycles); out_q/out_valid register one beat later.
// No back-pressure: every in_valid beat is captured, out_valid is a one-cycle strobe.
module or_16
  import or_16_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    or_16_or u_or (
      .a (a[i]),
      .b (b[i]),
      .y (out[i])
    );
  end

  // out_q holds its last capture when no beat arrives; only the strobe drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
      end
    end
  end

endmodule

// File: tb/tb_or_16.sv
// Directed vector bench for or_16: combinational table plus registered-path sequences.
module tb_or_16;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_valid;
  logic [15:0] out;
  logic [15:0] out_q;
  logic        out_valid;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  or_16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    a        = 16'h0000;
    b        = 16'h0000;
    in_valid = 1'b0;

    vecs[0] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{16'hAAAA, 16'h5555, 16'hFFFF};
    vecs[4] = '{16'h3CC3, 16'h0FF0, 16'h3FF3};
    vecs[5] = '{16'h1234, 16'h9876, 16'h9A76};

    #1;
    chk("reset_out_q", out_q, 16'h0000);
    chk("reset_out_valid", {15'd0, out_valid}, 16'h0000);
    chk("reset_out", out, 16'h0000);
    #11 rst = 1'b0;

    // combinational table, in_valid low so the strobe must stay quiet
    for (int i = 0; i < 6; i++) begin
      a = vecs[i].a;
      b = vecs[i].b;
      #1;
      chk($sformatf("comb_vec%0d", i), out, vecs[i].exp);
      #49;
      chk($sformatf("idle_valid%0d", i), {15'd0, out_valid}, 16'h0000);
    end

    // single captured beat, then hold
    @(negedge clk);
    a = 16'h1234; b = 16'h9876; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("cap_out_q", out_q, 16'h9A76);
    chk("cap_out_valid", {15'd0, out_valid}, 16'h0001);
    in_valid = 1'b0; a = 16'hFFFF; b = 16'h0000;
    @(posedge clk); #1;
    chk("hold_out_q", out_q, 16'h9A76);
    chk("hold_out_valid", {15'd0, out_valid}, 16'h0000);
    chk("hold_comb", out, 16'hFFFF);

    // back-to-back beats
    @(negedge clk);
    a = 16'h000F; b = 16'h00F0; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b0_out_q", out_q, 16'h00FF);
    chk("b2b0_valid", {15'd0, out_valid}, 16'h0001);
    a = 16'h0100; b = 16'h0001;
    @(posedge clk); #1;
    chk("b2b1_out_q", out_q, 16'h0101);
    chk("b2b1_valid", {15'd0, out_valid}, 16'h0001);

    // asynchronous reset between edges while a beat is valid
    #2 rst = 1'b1;
    #1;
    chk("arst_out_q", out_q, 16'h0000);
    chk("arst_valid", {15'd0, out_valid}, 16'h0000);
    chk("arst_comb", out, 16'h0101);
    @(posedge clk); #1;
    chk("arst_hold_q", out_q, 16'h0000);
    chk("arst_hold_valid", {15'd0, out_valid}, 16'h0000);

    // first capture after reset release
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out_q", out_q, 16'h0101);
    chk("post_rst_valid", {15'd0, out_valid}, 16'h0001);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_drop", {15'd0, out_valid}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
